// File: rtl/sp_pkg.sv
// Shared definitions for the serial-to-parallel receive path: state encoding
// and the frame/counter widths also used by the upstream serializer.
package sp_pkg;

    localparam int SP_WIDTH = 8;
    localparam int SP_CNT_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sp_state_t;

endpackage

// File: rtl/sp_shifter.sv
// MSB-first shift register with bit counter; strobes frame_done combinationally
// on the enabled cycle that carries the last bit of a frame.
module sp_shifter
    import sp_pkg::*;
#(
    parameter int WIDTH = SP_WIDTH
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             abort,
    output logic             frame_done,
    output logic [WIDTH-1:0] frame_data
);

    localparam int BC_W = $clog2(WIDTH + 1);

    // Only WIDTH-1 bits are stored: the final bit arrives live on bit_in.
    logic [WIDTH-2:0] sreg_reg;
    logic [BC_W-1:0]  bit_cnt_reg;

    assign frame_done = shift_en && (bit_cnt_reg == BC_W'(WIDTH - 1));
    assign frame_data = {sreg_reg, bit_in};

    always_ff @(posedge clk) begin
        if (!nReset) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (abort) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            sreg_reg    <= frame_data[WIDTH-2:0];
            bit_cnt_reg <= frame_done ? '0 : bit_cnt_reg + BC_W'(1);
        end
    end

endmodule

// File: rtl/sp_receiver.sv
// Reassembles serial frames into bytes, presents them with a valid/ack
// handshake, and reports aborted frames, overruns and a received-byte count.
module sp_receiver
    import sp_pkg::*;
#(
    parameter int WIDTH = SP_WIDTH,
    parameter int CNT_W = SP_CNT_W
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             Dbit_in,
    input  logic             Dbit_ena,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] rx_count
);

    sp_state_t        state_reg, state_next;
    logic             abort;
    logic             frame_done;
    logic [WIDTH-1:0] frame_data;

    logic [WIDTH-1:0] data_out_reg;
    logic             data_valid_reg;
    logic             frame_err_reg;
    logic             overrun_reg;
    logic [CNT_W-1:0] rx_count_reg;

    sp_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk        (clk),
        .nReset     (nReset),
        .shift_en   (Dbit_ena),
        .bit_in     (Dbit_in),
        .abort      (abort),
        .frame_done (frame_done),
        .frame_data (frame_data)
    );

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Dbit_ena && !frame_done) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!Dbit_ena) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else if (frame_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            rx_count_reg   <= '0;
        end else begin
            frame_err_reg <= abort;
            // A completion paired with an ack replaces the byte cleanly.
            overrun_reg   <= frame_done && data_valid_reg && !data_ack;
            if (frame_done) begin
                data_out_reg   <= frame_data;
                data_valid_reg <= 1'b1;
                rx_count_reg   <= rx_count_reg + CNT_W'(1);
            end else if (data_ack) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign rx_count   = rx_count_reg;

endmodule

// File: doc/sp_receiver.md
Name: sp_receiver

Overview:
- Downstream stage of the AD parallel-to-serial block.
- Consumes its serial stream (Dbit_out qualified by Dbit_ena) and reassembles 8-bit AD samples, MSB first.
- Presents each completed byte on a held parallel register with a valid/ack handshake toward the consumer.
- Flags truncated frames and unread-byte overruns, and keeps a wrap-around count of received bytes.

Parameters:
- WIDTH, 8, bits per serial frame and width of data_out.
- CNT_W, 16, width of the received-byte counter rx_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- Dbit_in  in  1  serial data from the upstream Dbit_out; MSB first.
- Dbit_ena  in  1  upstream bit-valid qualifier; one bit per clk cycle while high.
- data_out  out  WIDTH  last completed byte; held until overwritten.
- data_valid  out  1  data_out holds an unacknowledged byte.
- data_ack  in  1  consumer accepts data_out; effective only when data_valid=1.
- frame_err  out  1  one-cycle pulse: frame aborted before WIDTH bits.
- overrun  out  1  one-cycle pulse: unacknowledged byte was overwritten.
- rx_count  out  CNT_W  number of completed bytes; wraps modulo 2^CNT_W.

Behaviour:
- Reset: when nReset=0 at a clk edge, all registers clear: state=IDLE, shift reg=0, bit_cnt=0, data_out=0, data_valid=0, frame_err=0, overrun=0, rx_count=0.
  - Reset takes priority over every other event, including mid-frame; the partial frame is discarded with no frame_err.
- Sampling: Dbit_in is sampled only on edges where Dbit_ena=1. Bits shift in MSB first: sreg <= {sreg[WIDTH-2:0], Dbit_in}.
- FSM, two states:
  - IDLE:
    - Dbit_ena=1: sample first bit, bit_cnt=1, go to SHIFT.
    - Otherwise: hold.
  - SHIFT, with Dbit_ena=1:
    - Sample the bit and increment bit_cnt.
    - On the edge sampling bit WIDTH, load data_out <= {sreg[WIDTH-2:0], Dbit_in}, set data_valid=1, increment rx_count, clear bit_cnt, go to IDLE.
  - SHIFT, with Dbit_ena=0 and bit_cnt<WIDTH: frame_err=1 for exactly one cycle, discard the partial frame, bit_cnt=0, go to IDLE.
- Latency: data_out and data_valid are updated on the same edge that samples the last bit.
- Back-to-back frames: if Dbit_ena stays high past WIDTH bits, the next bit begins a new frame on the following edge with no gap cycle. Frames are exactly WIDTH contiguous enabled cycles.
- Handshake:
  - data_valid stays 1 until an edge where data_ack=1 and no byte completes; it then clears.
  - data_ack while data_valid=0 is ignored.
- Simultaneous completion and ack on the same edge: the new byte loads, data_valid stays 1, no overrun.
- Completion while data_valid=1 and data_ack=0: the new byte overwrites data_out, data_valid stays 1, overrun=1 for one cycle.
- rx_count increments on every completed frame, including overrun frames. It does not increment for aborted frames. It wraps from 2^CNT_W-1 to 0.
- frame_err and overrun never assert in the same cycle (they come from mutually exclusive events).
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package sp_pkg:
  - State encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1.
  - Default WIDTH and CNT_W constants, shared with the upstream parallel-to-serial block so frame width stays consistent.
- One sub-module, sp_shifter: shift register plus bit counter with a "frame_done" strobe and an abort input.
- Top-level sp_receiver holds the FSM, output register, handshake, error pulses and rx_count.

Test Plan:
1. Reset then single frame: nReset low 2 cycles; stream 8'b1001_1001 with Dbit_ena high 8 cycles; data_ack held 0 → data_out=8'h99 and data_valid=1 on the 8th sample edge, rx_count=1, no error pulses.
2. Handshake: after scenario 1, assert data_ack for 1 cycle → data_valid=0 next edge and data_out stays 8'h99. Then send 8'h9A and ack 3 cycles after completion → data_valid is high for exactly 3 cycles.
3. Back-to-back with overrun: Dbit_ena high for 16 cycles carrying 8'h9B then 8'h9C, no ack → data_out=8'h9B at edge 8 and 8'h9C at edge 16, overrun pulses once at edge 16, rx_count advances by 2.
4. Ack coincident with completion: hold data_ack=1 on the edge completing 8'h9D while data_valid=1 with the prior byte → data_out=8'h9D, data_valid=1, overrun=0.
5. Truncated frame: Dbit_ena high 5 cycles then low → frame_err pulses one cycle, data_out/data_valid/rx_count unchanged. A following full 8'hA0 frame is received correctly.
6. Reset mid-frame: nReset low after 4 bits of 8'hFF → all outputs 0 next edge, no frame_err. A full 8'h5A frame after release gives data_out=8'h5A and rx_count=1.
   - Wrap check: preload by sending 65536 frames → rx_count returns to 0.
